alu_seq: RTL and testbench

Instruction sequencer that drives the combinational ALU (sel/opA/opB in, res/z/c/v out) from the control side. It accepts 16-bit register-to-register instructions over a valid/ready handshake and reads operands from an internal 8x32 register file. It issues them to an external ALU instance, then commits the result to the register file and the flags to a Z/C/V register, with optional condition-code gating. It returns each result over a valid/ready output handshake.

---
 rtl/alu_seq_pkg.sv | 61 ++++++
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq_regfile.sv | 47 ++++
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcode/select encoding,
// condition codes, instruction field positions and the sequencer FSM states.
package alu_seq_pkg;

  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 16;

  // Opcodes double as the external ALU select codes.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_V  = 2'b11;

  // Flag register layout is {Z,C,V}.
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned RD_MSB   = 12;
  localparam int unsigned RD_LSB   = 10;
  localparam int unsigned RA_MSB   = 9;
  localparam int unsigned RA_LSB   = 7;
  localparam int unsigned RB_MSB   = 6;
  localparam int unsigned RB_LSB   = 4;
  localparam int unsigned COND_MSB = 3;
  localparam int unsigned COND_LSB = 2;
  localparam int unsigned SF_BIT   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_NOT);
  endfunction

  function automatic logic cond_met(input logic [1:0] cond, input logic [2:0] flags);
    logic met;
    unique case (cond)
      COND_AL: met = 1'b1;
      COND_Z:  met = flags[FLAG_Z];
      COND_C:  met = flags[FLAG_C];
      COND_V:  met = flags[FLAG_V];
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Instruction-in / response-out handshake bundle of the ALU sequencer.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic [2:0]    out_flags;
  logic          out_skip;
  logic          out_err;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_res, out_flags, out_skip, out_err
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_res, out_flags, out_skip, out_err
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// 8x32 register file: async reset, two combinational read ports and a
// synchronous write path shared by instruction commit and direct load.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cm_en,
  input  logic [AW-1:0] cm_addr,
  input  logic [DW-1:0] cm_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  // Write select per register so a load to a different register still lands
  // in a commit cycle; on an address clash the commit wins.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (cm_en && (cm_addr == AW'(i))) begin
        regs_d[i] = cm_data;
      end else if (ld_en && (ld_addr == AW'(i))) begin
        regs_d[i] = ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/alu_seq.sv
// Sequencer for an external combinational ALU: accepts an instruction, issues
// operands for one cycle, commits result/flags under condition, then responds.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_seq_if.slave      bus,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_opA,
  output logic [DW-1:0] alu_opB,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [1:0]    cond_q, cond_d;
  logic          sf_q, sf_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    flags_q, flags_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_res_q, out_res_d;
  logic [2:0]    out_flags_q, out_flags_d;
  logic          out_skip_q, out_skip_d;
  logic          out_err_q, out_err_d;

  logic          commit;
  logic          legal;
  logic [AW-1:0] ra_addr, rb_addr;
  logic [DW-1:0] ra_data, rb_data;
  logic          unused_rsvd;

  assign ra_addr     = bus.in_instr[RA_MSB:RA_LSB];
  assign rb_addr     = bus.in_instr[RB_MSB:RB_LSB];
  assign unused_rsvd = bus.in_instr[0];

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .cm_en   (commit),
    .cm_addr (rd_q),
    .cm_data (alu_res),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    cond_d      = cond_q;
    sf_d        = sf_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sel_d       = sel_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_flags_d = out_flags_q;
    out_skip_d  = out_skip_q;
    out_err_d   = out_err_q;
    legal       = op_legal(op_q);
    commit      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d       = bus.in_instr[OP_MSB:OP_LSB];
          rd_d       = bus.in_instr[RD_MSB:RD_LSB];
          cond_d     = bus.in_instr[COND_MSB:COND_LSB];
          sf_d       = bus.in_instr[SF_BIT];
          sel_d      = bus.in_instr[OP_MSB:OP_LSB];
          // Forward a load landing on this same edge so the operand sees it.
          opa_d      = (ld_en && (ld_addr == ra_addr)) ? ld_data : ra_data;
          opb_d      = (ld_en && (ld_addr == rb_addr)) ? ld_data : rb_data;
          in_ready_d = 1'b0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        commit = legal && cond_met(cond_q, flags_q);
        if (commit && sf_q) begin
          flags_d = {alu_z, alu_c, alu_v};
        end
        out_res_d   = commit ? alu_res : '0;
        out_flags_d = flags_d;
        out_skip_d  = !commit;
        out_err_d   = !legal;
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      cond_q      <= '0;
      sf_q        <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      sel_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
      out_skip_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      cond_q      <= cond_d;
      sf_q        <= sf_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sel_q       <= sel_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
      out_skip_q  <= out_skip_d;
      out_err_q   <= out_err_d;
    end
  end

  assign alu_opA       = opa_q;
  assign alu_opB       = opb_q;
  assign alu_sel       = sel_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_skip  = out_skip_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural ALU on the alu_* ports, directed vectors,
// multi-cycle corner sequences and randomized instructions against a model.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_opA, alu_opB, alu_res;
  logic [2:0]  alu_sel;
  logic        alu_z, alu_c, alu_v;

  alu_seq_if sif ();

  alu_seq dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (sif),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .alu_opA (alu_opA),
    .alu_opB (alu_opB),
    .alu_sel (alu_sel),
    .alu_res (alu_res),
    .alu_z   (alu_z),
    .alu_c   (alu_c),
    .alu_v   (alu_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: C is carry-out on ADD and borrow on SUB.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      3'd0: begin
        {alu_c, alu_res} = {1'b0, alu_opA} + {1'b0, alu_opB};
        alu_v = (alu_opA[31] == alu_opB[31]) && (alu_res[31] != alu_opA[31]);
      end
      3'd1: begin
        alu_res = alu_opA - alu_opB;
        alu_c   = alu_opA < alu_opB;
        alu_v   = (alu_opA[31] != alu_opB[31]) && (alu_res[31] != alu_opA[31]);
      end
      3'd2: alu_res = alu_opA & alu_opB;
      3'd3: alu_res = alu_opA | alu_opB;
      3'd4: alu_res = ~alu_opA;
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] enc(input int unsigned op, input int unsigned rd,
                                      input int unsigned ra, input int unsigned rb,
                                      input int unsigned cond, input int unsigned sf);
    logic [15:0] w;
    w = {op[2:0], rd[2:0], ra[2:0], rb[2:0], cond[1:0], sf[0], 1'b0};
    return w;
  endfunction

  // Reference model: architectural registers and {Z,C,V} flags.
  logic [31:0] m_r [8];
  logic [2:0]  m_f;

  task automatic model_exec(input logic [15:0] ins, output logic [31:0] res,
                            output logic [2:0] fl, output logic skip, output logic err);
    int unsigned op, rd, ra, rb, cond;
    logic        sf, ok, z, c, v;
    logic [31:0] a, b, r;
    longint      ua, ub, sa, sb, ws;
    op = ins[15:13]; rd = ins[12:10]; ra = ins[9:7]; rb = ins[6:4];
    cond = ins[3:2]; sf = ins[1];
    a = m_r[ra]; b = m_r[rb];
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      0: begin ws = ua + ub; r = ws[31:0]; c = ws >= 64'h1_0000_0000;
               ws = sa + sb; v = ws != longint'($signed(r)); end
      1: begin r = a - b; c = ua < ub; ws = sa - sb; v = ws != longint'($signed(r)); end
      2: r = a & b;
      3: r = a | b;
      4: r = ~a;
      default: r = '0;
    endcase
    z = (r == 0);
    case (cond)
      0: ok = 1'b1;
      1: ok = m_f[2];
      2: ok = m_f[1];
      default: ok = m_f[0];
    endcase
    err  = op > 4;
    skip = err || !ok;
    if (skip) begin
      res = '0;
    end else begin
      m_r[rd] = r;
      if (sf) m_f = {z, c, v};
      res = r;
    end
    fl = m_f;
  endtask

  task automatic load(input int unsigned addr, input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr[2:0]; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    m_r[addr] = data;
  endtask

  // One instruction, ready held high; optional load in the handshake or EXEC cycle.
  task automatic issue(input logic [15:0] ins, input logic [31:0] e_res, input logic [2:0] e_fl,
                       input logic e_skip, input logic e_err, input string tag,
                       input logic hs_ld, input logic ex_ld, input logic [2:0] la,
                       input logic [31:0] ldv);
    int unsigned n;
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_instr = ins;
    ld_en = hs_ld; ld_addr = la; ld_data = ldv;
    n = 0;
    while (!sif.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept"}, sif.in_ready, 1);
    if (!sif.in_ready) begin
      sif.in_valid = 1'b0; ld_en = 1'b0;
      return;
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    ld_en = ex_ld; ld_addr = la; ld_data = ldv;
    chk({tag, " exec in_ready"}, sif.in_ready, 0);
    chk({tag, " exec out_valid"}, sif.out_valid, 0);
    @(negedge clk);
    ld_en = 1'b0;
    chk({tag, " out_valid"}, sif.out_valid, 1);
    chk({tag, " out_res"}, sif.out_res, e_res);
    chk({tag, " out_flags"}, sif.out_flags, e_fl);
    chk({tag, " out_skip"}, sif.out_skip, e_skip);
    chk({tag, " out_err"}, sif.out_err, e_err);
    @(negedge clk);
    chk({tag, " drained out_valid"}, sif.out_valid, 0);
    chk({tag, " drained in_ready"}, sif.in_ready, 1);
  endtask

  task automatic run_model(input logic [15:0] ins, input string tag);
    logic [31:0] er; logic [2:0] ef; logic es, ee;
    model_exec(ins, er, ef, es, ee);
    issue(ins, er, ef, es, ee, tag, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [31:0] res;
    logic [2:0]  fl;
    logic        skip;
    logic        err;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] er, er2, cap;
    logic [2:0]  ef, ef2;
    logic        es, ee;
    logic [15:0] ins, ins2;
    logic [31:0] specials [4];

    vt[0]  = '{enc(0,3,1,2,0,1), 32'h8000_0000, 3'b001, 1'b0, 1'b0};
    vt[1]  = '{enc(1,3,3,3,0,1), 32'h0000_0000, 3'b100, 1'b0, 1'b0};
    vt[2]  = '{enc(0,4,1,2,1,0), 32'h8000_0000, 3'b100, 1'b0, 1'b0};
    vt[3]  = '{enc(0,5,1,1,3,0), 32'h0000_0000, 3'b100, 1'b1, 1'b0};
    vt[4]  = '{enc(3,5,5,5,0,0), 32'h1234_5678, 3'b100, 1'b0, 1'b0};
    vt[5]  = '{enc(6,1,2,2,0,1), 32'h0000_0000, 3'b100, 1'b1, 1'b1};
    vt[6]  = '{enc(3,1,1,1,0,0), 32'h7FFF_FFFF, 3'b100, 1'b0, 1'b0};
    vt[7]  = '{enc(4,6,2,0,0,1), 32'hFFFF_FFFE, 3'b000, 1'b0, 1'b0};
    vt[8]  = '{enc(0,7,6,6,0,1), 32'hFFFF_FFFC, 3'b010, 1'b0, 1'b0};
    vt[9]  = '{enc(0,0,2,2,2,0), 32'h0000_0002, 3'b010, 1'b0, 1'b0};
    vt[10] = '{enc(3,0,0,0,0,0), 32'h0000_0002, 3'b010, 1'b0, 1'b0};
    vt[11] = '{enc(2,1,1,5,0,1), 32'h1234_5678, 3'b000, 1'b0, 1'b0};
    specials[0] = 32'h0000_0000; specials[1] = 32'h7FFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'hFFFF_FFFF;

    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_f = '0;
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    sif.in_valid = 1'b0; sif.in_instr = '0; sif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", sif.in_ready, 1);
    chk("reset out_valid", sif.out_valid, 0);
    chk("reset out_res", sif.out_res, 0);
    chk("reset out_flags", sif.out_flags, 0);
    chk("reset out_skip", sif.out_skip, 0);
    chk("reset out_err", sif.out_err, 0);
    chk("reset alu_sel", alu_sel, 0);
    chk("reset alu_opA", alu_opA, 0);

    load(1, 32'h7FFF_FFFF);
    load(2, 32'h0000_0001);
    load(5, 32'h1234_5678);
    for (int i = 0; i < 12; i++) begin
      model_exec(vt[i].ins, er, ef, es, ee);
      issue(vt[i].ins, vt[i].res, vt[i].fl, vt[i].skip, vt[i].err,
            $sformatf("vec%0d", i), 1'b0, 1'b0, 3'd0, 32'd0);
    end

    // Back-pressure: response held for 5 cycles, a queued instruction waits.
    ins  = enc(0, 3, 1, 2, 0, 1);
    ins2 = enc(1, 7, 3, 2, 0, 1);
    model_exec(ins, er, ef, es, ee);
    sif.out_ready = 1'b0;
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_instr = ins;
    chk("stall accept", sif.in_ready, 1);
    @(negedge clk);
    sif.in_instr = ins2;
    @(negedge clk);
    chk("stall out_valid", sif.out_valid, 1);
    chk("stall out_res", sif.out_res, er);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall hold in_ready", sif.in_ready, 0);
      chk("stall hold out_valid", sif.out_valid, 1);
      chk("stall hold out_res", sif.out_res, er);
      chk("stall hold out_flags", sif.out_flags, ef);
    end
    sif.out_ready = 1'b1;
    model_exec(ins2, er2, ef2, es, ee);
    @(negedge clk);
    chk("release in_ready", sif.in_ready, 1);
    chk("release out_valid", sif.out_valid, 0);
    @(negedge clk);
    sif.in_valid = 1'b0;
    chk("next exec in_ready", sif.in_ready, 0);
    @(negedge clk);
    chk("next out_valid", sif.out_valid, 1);
    chk("next out_res", sif.out_res, er2);
    chk("next out_flags", sif.out_flags, ef2);
    @(negedge clk);
    chk("next drained", sif.out_valid, 0);

    // Load and commit to R4 on the same edge: commit wins.
    ins = enc(0, 4, 1, 2, 0, 0);
    model_exec(ins, er, ef, es, ee);
    issue(ins, er, ef, es, ee, "collide", 1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF);
    run_model(enc(3, 4, 4, 4, 0, 0), "collide readback");

    // Load to R5 in the handshake cycle feeds the operand.
    m_r[5] = 32'h0000_0100;
    ins = enc(0, 6, 5, 2, 0, 0);
    model_exec(ins, er, ef, es, ee);
    issue(ins, er, ef, es, ee, "hs load", 1'b1, 1'b0, 3'd5, 32'h0000_0100);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) load($urandom_range(0, 7), $urandom);
        else load($urandom_range(0, 7), specials[$urandom_range(0, 3)]);
      end
      ins = enc(($urandom_range(0, 7) < 6) ? $urandom_range(0, 4) : $urandom_range(5, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 1));
      ins[0] = $urandom_range(0, 1);
      run_model(ins, $sformatf("rand%0d", i));
    end

    // Asynchronous reset while an instruction is in EXEC.
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_instr = enc(3, 7, 1, 1, 0, 1);
    @(negedge clk);
    sif.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst exec out_valid", sif.out_valid, 0);
    chk("rst exec in_ready", sif.in_ready, 1);
    chk("rst exec out_flags", sif.out_flags, 0);
    chk("rst exec out_res", sif.out_res, 0);
    chk("rst exec alu_sel", alu_sel, 0);
    chk("rst exec alu_opB", alu_opB, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_f = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post rst out_valid", sif.out_valid, 0);
      chk("post rst in_ready", sif.in_ready, 1);
    end
    for (int r = 0; r < 8; r++) run_model(enc(3, r, r, r, 0, 0), $sformatf("post rst R%0d", r));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
